// File: rtl/tff_bank_pkg.sv
// Shared constants and helpers for the toggle flip-flop bank.
package tff_bank_pkg;

  localparam int   SYNC_STAGES = 2;
  localparam logic MODE_LEVEL  = 1'b0;
  localparam logic MODE_EDGE   = 1'b1;

  // Select width never drops below one bit, even for a single channel.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tff_bank_if.sv
// Control/status bundle between the toggle bank and its host logic.
interface tff_bank_if #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8
);
  localparam int SEL_W = tff_bank_pkg::sel_width(N_CH);

  logic              en;
  logic              clr;
  logic              load;
  logic [N_CH-1:0]   load_val;
  logic [N_CH-1:0]   edge_mode;
  logic [N_CH-1:0]   t_in;
  logic [SEL_W-1:0]  cnt_sel;
  logic [N_CH-1:0]   q;
  logic [N_CH-1:0]   tgl_pulse;
  logic [CNT_W-1:0]  cnt_out;
  logic [N_CH-1:0]   cnt_sat;

  modport master (
    output en, clr, load, load_val, edge_mode, t_in, cnt_sel,
    input  q, tgl_pulse, cnt_out, cnt_sat
  );

  modport slave (
    input  en, clr, load, load_val, edge_mode, t_in, cnt_sel,
    output q, tgl_pulse, cnt_out, cnt_sat
  );
endinterface

// File: rtl/tff_channel.sv
// One toggle channel: T qualification, q, toggle pulse, saturating counter.
// TFF_BANK_SYNC_EN inserts a two-flop synchronizer ahead of edge detection.
module tff_channel
  import tff_bank_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic             load_val,
  input  logic             edge_mode,
  input  logic             t_in,
  output logic             q,
  output logic             tgl_pulse,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic t_eff;
  logic t_prev;
  logic req;

`ifdef TFF_BANK_SYNC_EN
  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], t_in};
  end

  assign t_eff = sync[SYNC_STAGES-1];
`else
  assign t_eff = t_in;
`endif

  assign req = (edge_mode == MODE_EDGE) ? (t_eff & ~t_prev) : t_eff;

  // Edge history tracks every cycle so a rise while disabled is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_prev    <= 1'b0;
      q         <= 1'b0;
      tgl_pulse <= 1'b0;
      cnt       <= '0;
      sat       <= 1'b0;
    end else begin
      t_prev <= t_eff;
      if (clr) begin
        q         <= 1'b0;
        tgl_pulse <= 1'b0;
        cnt       <= '0;
        sat       <= 1'b0;
      end else if (load) begin
        q         <= load_val;
        tgl_pulse <= 1'b0;
      end else if (en && req) begin
        q         <= ~q;
        tgl_pulse <= 1'b1;
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (cnt == CNT_MAX - 1'b1) sat <= 1'b1;
      end else begin
        tgl_pulse <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tff_bank.sv
// N_CH-channel toggle bank with a registered counter read-back mux.
// Optional input synchronizers are enabled with TFF_BANK_SYNC_EN.
module tff_bank
  import tff_bank_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8
) (
  input logic       clk,
  input logic       rst,
  tff_bank_if.slave bus
);

  localparam int SEL_W = sel_width(N_CH);

  logic [N_CH-1:0]  q_w;
  logic [N_CH-1:0]  tgl_w;
  logic [N_CH-1:0]  sat_w;
  logic [CNT_W-1:0] cnt_w [N_CH];
  logic [CNT_W-1:0] sel_cnt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tff_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.en),
      .clr       (bus.clr),
      .load      (bus.load),
      .load_val  (bus.load_val[i]),
      .edge_mode (bus.edge_mode[i]),
      .t_in      (bus.t_in[i]),
      .q         (q_w[i]),
      .tgl_pulse (tgl_w[i]),
      .cnt       (cnt_w[i]),
      .sat       (sat_w[i])
    );
  end

  assign bus.q         = q_w;
  assign bus.tgl_pulse = tgl_w;
  assign bus.cnt_sat   = sat_w;

  // Out-of-range selects match no channel and read back as zero.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.cnt_sel == SEL_W'(i)) sel_cnt = cnt_w[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.cnt_out <= '0;
    else     bus.cnt_out <= sel_cnt;
  end

endmodule

// File: tb/tb_tff_bank.sv
// Scoreboard bench for tff_bank: an 8-channel/8-bit and a 6-channel/2-bit instance.
module tb_tff_bank;

`ifdef TFF_BANK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int DL = LAT - 1;

  localparam int F_Q   = 0;
  localparam int F_TGL = 1;
  localparam int F_CNT = 2;
  localparam int F_SAT = 3;

  typedef struct {
    int          cyc;
    int          dut;
    int          fld;
    logic [31:0] mask;
    logic [31:0] val;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tff_bank_if #(.N_CH(8), .CNT_W(8)) b8 ();
  tff_bank_if #(.N_CH(6), .CNT_W(2)) b6 ();

  tff_bank #(.N_CH(8), .CNT_W(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  tff_bank #(.N_CH(6), .CNT_W(2)) u6 (.clk(clk), .rst(rst), .bus(b6));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  function automatic logic [31:0] act(input int dut, input int fld);
    if (dut == 0) begin
      case (fld)
        F_Q:     return 32'(b8.q);
        F_TGL:   return 32'(b8.tgl_pulse);
        F_CNT:   return 32'(b8.cnt_out);
        default: return 32'(b8.cnt_sat);
      endcase
    end else begin
      case (fld)
        F_Q:     return 32'(b6.q);
        F_TGL:   return 32'(b6.tgl_pulse);
        F_CNT:   return 32'(b6.cnt_out);
        default: return 32'(b6.cnt_sat);
      endcase
    end
  endfunction

  task automatic ex(input int d, input int dut, input int fld, input logic [31:0] mask,
                    input logic [31:0] val, input string nm);
    exp_t e;
    e.cyc = cyc + d; e.dut = dut; e.fld = fld; e.mask = mask; e.val = val; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk(sb[i].nm, act(sb[i].dut, sb[i].fld) & sb[i].mask, sb[i].val);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        chk({sb[i].nm, "_stale"}, 32'(sb[i].cyc), 32'(cyc));
        sb.delete(i);
      end
    end
  end

  initial begin
    b8.en = 0; b8.clr = 0; b8.load = 0; b8.load_val = '0;
    b8.edge_mode = '0; b8.t_in = '0; b8.cnt_sel = '0;
    b6.en = 0; b6.clr = 0; b6.load = 0; b6.load_val = '0;
    b6.edge_mode = '0; b6.t_in = '0; b6.cnt_sel = '0;

    // Reset state and first edge after release
    step(2);
    ex(0, 0, F_Q,   32'hff, 0, "rst_q");
    ex(0, 0, F_TGL, 32'hff, 0, "rst_tgl");
    ex(0, 0, F_CNT, 32'hff, 0, "rst_cnt");
    ex(0, 0, F_SAT, 32'hff, 0, "rst_sat");
    rst = 0;
    ex(1, 0, F_Q, 32'hff, 0, "rel_q");
    step(1);

    // Load then asynchronous reset between edges
    b8.load = 1; b8.load_val = 8'ha5;
    ex(1, 0, F_Q, 32'hff, 32'ha5, "load_a5");
    step(1);
    b8.load = 0;
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("async_rst_q",   32'(b8.q), 0);
    chk("async_rst_cnt", 32'(b8.cnt_out), 0);
    chk("async_rst_sat", 32'(b8.cnt_sat), 0);
    @(posedge clk);
    #1 rst = 0;
    ex(1, 0, F_Q, 32'hff, 0, "rst_mid_first_edge");
    step(2);

    // Level mode, channel 0, six requests
    b8.edge_mode = '0; b8.en = 1; b8.cnt_sel = 0; b8.t_in = 8'h01;
    ex(DL, 0, F_Q, 1, 0, "lvl_pre");
    for (int j = 1; j <= 6; j++) begin
      ex(j + DL,     0, F_Q,   1, 32'(j % 2), $sformatf("lvl_q%0d", j));
      ex(j + DL,     0, F_TGL, 1, 1,          $sformatf("lvl_tgl%0d", j));
      ex(j + 1 + DL, 0, F_CNT, 32'hff, 32'(j), $sformatf("lvl_cnt%0d", j));
    end
    ex(7 + DL, 0, F_TGL, 1, 0, "lvl_tgl_end");
    ex(8 + DL, 0, F_Q,   1, 0, "lvl_hold");
    step(6);
    b8.t_in = 8'h00;
    step(3 + DL);

    // Edge mode, channel 3: high 5, low 2, high 1
    b8.edge_mode = 8'h08; b8.t_in = 8'h08;
    ex(1 + DL, 0, F_Q,   8, 8, "edg_first_q");
    ex(1 + DL, 0, F_TGL, 8, 8, "edg_first_tgl");
    ex(2 + DL, 0, F_TGL, 8, 0, "edg_one_pulse");
    ex(5 + DL, 0, F_Q,   8, 8, "edg_held_q");
    step(5);
    b8.t_in = 8'h00;
    step(2);
    b8.t_in = 8'h08;
    ex(1 + DL, 0, F_Q,   8, 0, "edg_second_q");
    ex(1 + DL, 0, F_TGL, 8, 8, "edg_second_tgl");
    step(1);
    b8.t_in = 8'h00;
    step(DL);
    b8.cnt_sel = 3;
    ex(1, 0, F_CNT, 32'hff, 2, "edg_cnt");
    ex(1, 0, F_TGL, 8, 0, "edg_tgl_end");
    step(2);

    // Priority: clr over load over toggle, then load alone
    b8.clr = 1; b8.load = 1; b8.load_val = 8'hff; b8.t_in = 8'hff; b8.cnt_sel = 0;
    ex(1, 0, F_Q,   32'hff, 0, "pri_clr_q");
    ex(1, 0, F_TGL, 32'hff, 0, "pri_clr_tgl");
    ex(1, 0, F_CNT, 32'hff, 6, "pri_cnt_before");
    ex(2, 0, F_CNT, 32'hff, 0, "pri_cnt_clr");
    step(1);
    b8.clr = 0;
    ex(1, 0, F_Q,   32'hff, 32'hff, "pri_load_q");
    ex(1, 0, F_TGL, 32'hff, 0,      "pri_load_tgl");
    step(1);
    b8.t_in = 8'h00;
    step(LAT);
    b8.load = 0;
    ex(1, 0, F_CNT, 32'hff, 0,      "pri_load_cnt");
    ex(1, 0, F_Q,   32'hff, 32'hff, "pri_hold_q");
    step(2 + DL);

    // Rising edge while disabled is lost
    b8.edge_mode = 8'h20; b8.en = 0; b8.t_in = 8'h20;
    for (int d = 1; d <= LAT + 2; d++) begin
      ex(d, 0, F_Q,   32'hff, 32'hff, $sformatf("en_gate_q%0d", d));
      ex(d, 0, F_TGL, 32'hff, 0,      $sformatf("en_gate_tgl%0d", d));
    end
    step(LAT);
    b8.en = 1;
    step(3);
    b8.t_in = 8'h00;
    step(2);

    // Saturation on the 2-bit instance, out-of-range select, clear
    b6.en = 1; b6.edge_mode = '0; b6.cnt_sel = 1; b6.t_in = 6'h02;
    for (int j = 1; j <= 5; j++)
      ex(j + 1 + DL, 1, F_CNT, 3, (j >= 3) ? 32'd3 : 32'(j), $sformatf("sat_cnt%0d", j));
    ex(2 + DL, 1, F_SAT, 2, 0, "sat_pre");
    ex(3 + DL, 1, F_SAT, 2, 2, "sat_set");
    ex(5 + DL, 1, F_SAT, 2, 2, "sat_hold");
    ex(5 + DL, 1, F_Q,   2, 2, "sat_q");
    step(5);
    b6.t_in = 6'h00;
    step(1 + DL);
    b6.cnt_sel = 7;
    ex(1, 1, F_CNT, 3, 0, "sel_oor");
    step(1);
    b6.clr = 1; b6.cnt_sel = 1;
    ex(1, 1, F_CNT, 3, 3, "sat_cnt_keep");
    ex(1, 1, F_Q,   2, 0, "clr_q");
    ex(1, 1, F_SAT, 2, 0, "clr_sat");
    ex(2, 1, F_CNT, 3, 0, "clr_cnt");
    step(1);
    b6.clr = 0;
    step(4);

    chk("sb_drain", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
